// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - synchronous first-word-fall-through FIFO with programmable levels
//
// Purpose: single-clock FIFO of DEPTH = 2^ADDR_BITS words. The head word is
// shown on data_r without a read request. The block provides registered
// full/empty/almost flags, data/space counts, a one-cycle flush, and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              clear contents in one cycle; error flags are kept
//   clr_err            clear overflow/underflow (a set in the same cycle wins)
//   en_w, data_w       write request and data
//   full_w, afull_w    full, almost full (data_count >= af_level)
//   space_count        free entries, 0..DEPTH
//   overflow           sticky: write requested while full
//   en_r               pop request
//   data_r             head word, valid while empty_r = 0
//   empty_r, aempty_r  empty, almost empty (data_count <= ae_level)
//   data_count         stored words, 0..DEPTH
//   underflow          sticky: read requested while empty
//   af_level, ae_level almost-full / almost-empty thresholds
module fifo_fwft #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 clr_err,
  input  logic                 en_w,
  input  logic [DATA_BITS-1:0] data_w,
  output logic                 full_w,
  output logic                 afull_w,
  output logic [ADDR_BITS:0]   space_count,
  output logic                 overflow,
  input  logic                 en_r,
  output logic [DATA_BITS-1:0] data_r,
  output logic                 empty_r,
  output logic                 aempty_r,
  output logic [ADDR_BITS:0]   data_count,
  output logic                 underflow,
  input  logic [ADDR_BITS:0]   af_level,
  input  logic [ADDR_BITS:0]   ae_level
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_V = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ZERO_V  = '0;

  logic [DATA_BITS-1:0] mem [0:DEPTH-1];

  logic [ADDR_BITS:0]   ptr_w;
  logic [ADDR_BITS:0]   ptr_r;
  logic [ADDR_BITS:0]   ptr_w_nxt;
  logic [ADDR_BITS:0]   ptr_r_nxt;
  logic [ADDR_BITS:0]   cnt_nxt;
  logic [DATA_BITS-1:0] head_nxt;
  logic                 wr_acc;
  logic                 rd_acc;

  // Acceptance uses the registered flags, so a full FIFO never writes
  // through and an empty FIFO never reads through.
  always_comb begin
    wr_acc    = en_w & ~full_w;
    rd_acc    = en_r & ~empty_r;
    ptr_w_nxt = ptr_w + {{ADDR_BITS{1'b0}}, wr_acc};
    ptr_r_nxt = ptr_r + {{ADDR_BITS{1'b0}}, rd_acc};
    cnt_nxt   = ptr_w_nxt - ptr_r_nxt;
    // The word being written this cycle becomes the head when the next read
    // pointer lands on the write slot; the RAM does not hold it yet.
    if (wr_acc && (ptr_w == ptr_r_nxt)) begin
      head_nxt = data_w;
    end else begin
      head_nxt = mem[ptr_r_nxt[ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[ptr_w[ADDR_BITS-1:0]] <= data_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_w       <= '0;
      ptr_r       <= '0;
      data_count  <= '0;
      space_count <= DEPTH_V;
      full_w      <= 1'b0;
      empty_r     <= 1'b1;
      afull_w     <= 1'b0;
      aempty_r    <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      data_r      <= '0;
    end else if (flush) begin
      // Requests during flush are ignored and raise no error.
      ptr_w       <= '0;
      ptr_r       <= '0;
      data_count  <= '0;
      space_count <= DEPTH_V;
      full_w      <= 1'b0;
      empty_r     <= 1'b1;
      afull_w     <= 1'b0;
      aempty_r    <= 1'b1;
      overflow    <= overflow & ~clr_err;
      underflow   <= underflow & ~clr_err;
    end else begin
      ptr_w       <= ptr_w_nxt;
      ptr_r       <= ptr_r_nxt;
      data_count  <= cnt_nxt;
      space_count <= DEPTH_V - cnt_nxt;
      full_w      <= (cnt_nxt == DEPTH_V);
      empty_r     <= (cnt_nxt == ZERO_V);
      afull_w     <= (cnt_nxt >= af_level);
      aempty_r    <= (cnt_nxt <= ae_level);
      // Set has priority over clear.
      overflow    <= (en_w & full_w) | (overflow & ~clr_err);
      underflow   <= (en_r & empty_r) | (underflow & ~clr_err);
      // When going empty the last presented word is simply held.
      if (cnt_nxt != ZERO_V) begin
        data_r <= head_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft.sv
// tb/tb_fifo_fwft.sv - scoreboard testbench for fifo_fwft
module tb_fifo_fwft;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          en_w = 1'b0;
  logic [DW-1:0] data_w = '0;
  logic          full_w;
  logic          afull_w;
  logic [AW:0]   space_count;
  logic          overflow;
  logic          en_r = 1'b0;
  logic [DW-1:0] data_r;
  logic          empty_r;
  logic          aempty_r;
  logic [AW:0]   data_count;
  logic          underflow;
  logic [AW:0]   af_level = 4'd6;
  logic [AW:0]   ae_level = 4'd2;

  fifo_fwft #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .en_w(en_w), .data_w(data_w), .full_w(full_w), .afull_w(afull_w),
    .space_count(space_count), .overflow(overflow),
    .en_r(en_r), .data_r(data_r), .empty_r(empty_r), .aempty_r(aempty_r),
    .data_count(data_count), .underflow(underflow),
    .af_level(af_level), .ae_level(ae_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  // Reference model state, as it should look after the most recent edge.
  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_af  = 1'b0;
  logic          m_ae  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected word for an accepted
  // write, then advance the model across the edge.
  task automatic step(input bit w, input logic [DW-1:0] dw, input bit r,
                      input bit fl, input bit ce, input bit rs);
    bit wa, ra;
    int nc;
    logic no, nu, naf, nae;
    en_w = w; data_w = dw; en_r = r; flush = fl; clr_err = ce; rst = rs;
    wa = w && (m_cnt < DEPTH) && !fl && !rs;
    ra = r && (m_cnt > 0) && !fl && !rs;
    if (wa) exp_q.push_back(dw);
    nc  = m_cnt + int'(wa) - int'(ra);
    naf = (nc >= int'(af_level));
    nae = (nc <= int'(ae_level));
    no  = (w && m_cnt == DEPTH && !fl) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    nu  = (r && m_cnt == 0 && !fl) ? 1'b1 : (ce ? 1'b0 : m_unf);
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_af = 1'b0; m_ae = 1'b1;
      exp_q.delete();
    end else if (fl) begin
      m_cnt = 0; m_af = 1'b0; m_ae = 1'b1;
      m_ovf = ce ? 1'b0 : m_ovf;
      m_unf = ce ? 1'b0 : m_unf;
      exp_q.delete();
    end else begin
      m_cnt = nc; m_af = naf; m_ae = nae; m_ovf = no; m_unf = nu;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] dw);
    step(1'b1, dw, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_errors();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: compares flags against the model every cycle and pops the
  // scoreboard whenever the DUT presents a word that is being consumed.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("data_count", 64'(data_count), 64'(m_cnt));
      chk("space_count", 64'(space_count), 64'(DEPTH - m_cnt));
      chk("empty_r", 64'(empty_r), 64'(m_cnt == 0));
      chk("full_w", 64'(full_w), 64'(m_cnt == DEPTH));
      chk("afull_w", 64'(afull_w), 64'(m_af));
      chk("aempty_r", 64'(aempty_r), 64'(m_ae));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
      if (en_r && !empty_r && !flush && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop: DUT presents %0h with no expected word at %0t", data_r, $time);
        end else begin
          chk("data_r", 64'(data_r), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  int rst_at;

  initial begin
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data_r", 64'(data_r), 64'h0);
    chk("rst_space", 64'(space_count), 64'd8);
    chk("rst_empty", 64'(empty_r), 64'h1);
    chk("rst_aempty", 64'(aempty_r), 64'h1);
    mon_on = 1'b1;
    idle();

    // Fill to DEPTH, then one more write overflows without changing contents.
    for (int i = 0; i < DEPTH; i++) wr(DW'(i));
    chk("fill_full", 64'(full_w), 64'h1);
    chk("fill_count", 64'(data_count), 64'd8);
    chk("fill_space", 64'(space_count), 64'd0);
    chk("fill_ovf", 64'(overflow), 64'h0);
    wr(32'hDEAD);
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_head", 64'(data_r), 64'h0);
    for (int i = 0; i < DEPTH; i++) rd();
    clear_errors();
    chk("ovf_clr", 64'(overflow), 64'h0);

    // Single word fall-through, then underflow.
    wr(32'hA5);
    chk("fwft_empty", 64'(empty_r), 64'h0);
    chk("fwft_data", 64'(data_r), 64'hA5);
    rd();
    chk("pop_empty", 64'(empty_r), 64'h1);
    rd();
    chk("unf_set", 64'(underflow), 64'h1);
    clear_errors();
    chk("unf_clr", 64'(underflow), 64'h0);

    // Full with simultaneous read/write: the read wins, then streaming.
    for (int i = 0; i < DEPTH; i++) wr(DW'(i));
    for (int i = 0; i < 20; i++) step(1'b1, DW'(8 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stream_ovf", 64'(overflow), 64'h1);
    chk("stream_count", 64'(data_count), 64'd7);
    while (m_cnt > 0) rd();
    clear_errors();

    // Almost-full / almost-empty thresholds (af=6, ae=2).
    for (int i = 0; i < 7; i++) begin
      wr(DW'(100 + i));
      if (i == 4) chk("af_at5", 64'(afull_w), 64'h0);
      if (i == 5) chk("af_at6", 64'(afull_w), 64'h1);
    end
    for (int i = 0; i < 7; i++) begin
      rd();
      if (i == 1) chk("af_fall5", 64'(afull_w), 64'h0);
      if (i == 3) chk("ae_at3", 64'(aempty_r), 64'h0);
      if (i == 4) chk("ae_at2", 64'(aempty_r), 64'h1);
    end

    // Flush with a concurrent write; error flags survive.
    rd();
    for (int i = 0; i < 5; i++) wr(DW'(200 + i));
    step(1'b1, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", 64'(data_count), 64'd0);
    chk("flush_empty", 64'(empty_r), 64'h1);
    chk("flush_unf_kept", 64'(underflow), 64'h1);
    wr(32'h3C);
    chk("post_flush_data", 64'(data_r), 64'h3C);
    rd();
    clear_errors();

    // Random traffic with one reset at a random point.
    rst_at = $urandom_range(2000, 8000);
    for (int i = 0; i < 10000; i++) begin
      bit w, r, fl, ce;
      w  = ($urandom_range(0, 99) < (((i / 300) % 2) ? 70 : 35));
      r  = ($urandom_range(0, 99) < (((i / 300) % 2) ? 35 : 70));
      fl = ($urandom_range(0, 255) == 0);
      ce = ($urandom_range(0, 63) == 0);
      if (i == rst_at) begin
        step(w, DW'($urandom), r, 1'b0, 1'b0, 1'b1);
        chk("rnd_rst_data_r", 64'(data_r), 64'h0);
        chk("rnd_rst_count", 64'(data_count), 64'd0);
      end else begin
        step(w, DW'($urandom), r, fl, ce, 1'b0);
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
